// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle ripple adder. It computes a + b + cin over N bits and handles K
// bits per clock. A single carry register links one slice to the next.
// The sum is assembled least-significant slice first in a right-shifting
// register. The block also reports carry-out and two's-complement overflow.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operands a/b/cin present
//   in_ready   block idle and able to accept operands
//   a, b       N-bit addends
//   cin        carry-in
//   out_valid  s/cout/ovf hold a finished result
//   out_ready  consumer takes the result
//   s          N-bit sum (modulo 2^N)
//   cout       carry out of bit N-1
//   ovf        signed overflow
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int SLICES = N / K;
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(SLICES - 1);

    // Reject illegal widths at elaboration rather than building a broken adder.
    if (N < 1 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
        $error("serial_adder: N must be >= 1, 1 <= K <= N and N %% K == 0");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [N-1:0]    op_a_r;
    logic [N-1:0]    op_b_r;
    logic [N-1:0]    sum_r;
    logic            carry_r;
    logic [CW-1:0]   cnt_r;
    logic            msb_a_r;
    logic            msb_b_r;
    logic            cout_r;
    logic            ovf_r;

    logic [K:0]      slice_s;
    logic [N+K-1:0]  sum_cat_s;
    logic            last_slice_s;

    // Overflow: carry into the MSB (msb_a ^ msb_b ^ msb_sum) XOR carry out.
    function automatic logic ovf_calc(input logic op_a_msb, input logic op_b_msb,
                                      input logic sum_msb, input logic carry_out);
        return op_a_msb ^ op_b_msb ^ sum_msb ^ carry_out;
    endfunction

    // Slice adder and the sum-register shift value.
    always_comb begin
        slice_s      = {1'b0, op_a_r[K-1:0]} + {1'b0, op_b_r[K-1:0]} + {{K{1'b0}}, carry_r};
        // New slice enters at the top; the old contents move down by K. The
        // concatenation form also works when K == N.
        sum_cat_s    = {slice_s[K-1:0], sum_r};
        last_slice_s = (cnt_r == LAST_SLICE);
    end

    // Next-state decode for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_slice_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: operand capture on accept, one K-bit slice per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_r  <= '0;
            op_b_r  <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            msb_a_r <= 1'b0;
            msb_b_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_a_r  <= a;
                        op_b_r  <= b;
                        carry_r <= cin;
                        msb_a_r <= a[N-1];
                        msb_b_r <= b[N-1];
                        cnt_r   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_r   <= sum_cat_s[N+K-1:K];
                    carry_r <= slice_s[K];
                    op_a_r  <= op_a_r >> K;
                    op_b_r  <= op_b_r >> K;
                    cnt_r   <= cnt_r + CW'(1);
                    // Flags are only updated from the final slice, so they
                    // stay stable with s for the whole DONE phase.
                    if (last_slice_s) begin
                        cout_r <= slice_s[K];
                        ovf_r  <= ovf_calc(msb_a_r, msb_b_r, slice_s[K-1], slice_s[K]);
                    end
                end
                default: begin
                    // DONE: hold everything until the consumer takes it.
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign s         = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// The bench builds one serial_adder instance for each (N,K) configuration. Each
// instance has a driver and a scoreboard monitor. The driver pushes the
// expected {cout, ovf, s} when it issues operands. The monitor pops and
// compares on every output handshake. The monitor also measures latency from
// the accept edge to the rise of out_valid.
// Configuration 0 (N=8, K=2) runs the directed vectors: basic sum, carry wrap,
// backpressure and reset in the middle of RUN. The other configurations run
// operand sweeps with corner values.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int NCFG = 5;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cfg_n(input int i);
        case (i)
            0:       return 8;
            1:       return 8;
            2:       return 8;
            3:       return 32;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_k(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 8;
            3:       return 4;
            default: return 32;
        endcase
    endfunction

    task automatic check(input int g, input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0h expected %0h", g, name, got, want);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int NN   = cfg_n(g);
        localparam int KK   = cfg_k(g);
        localparam int LAT  = NN / KK;
        localparam int NOPS = (g == 0) ? 7 : 1000;

        logic          reset, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
        logic [NN-1:0] a, b, s;
        logic [NN+1:0] exp_q[$];

        serial_adder #(.N(NN), .K(KK)) dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .s         (s),
            .cout      (cout),
            .ovf       (ovf)
        );

        // Monitor: samples on the falling edge, between driver updates.
        initial begin
            logic [NN+1:0] e;
            logic          ov_prev;
            int            acc_cyc;
            ov_prev = 1'b0;
            acc_cyc = 0;
            forever begin
                @(negedge clk);
                if (reset) begin
                    ov_prev = 1'b0;
                end else begin
                    if (in_valid && in_ready) acc_cyc = cyc + 1;
                    if (out_valid && !ov_prev)
                        check(g, "latency", 64'(cyc - acc_cyc), 64'(LAT));
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check(g, "unexpected_result", 64'(1), 64'(0));
                        end else begin
                            e = exp_q.pop_front();
                            check(g, "sum",  64'(s),    64'(e[NN-1:0]));
                            check(g, "cout", 64'(cout), 64'(e[NN+1]));
                            check(g, "ovf",  64'(ovf),  64'(e[NN]));
                        end
                    end
                    ov_prev = out_valid;
                end
            end
        end

        // Driver: inputs change 1 time unit after the rising edge.
        initial begin
            logic [NN-1:0] va, vb, es;
            logic          vc, ec, eo;
            logic [NN:0]   full;
            int            act, n;
            reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
            a = '0; b = '0; cin = 1'b0;
            repeat (3) @(posedge clk);
            #1 reset = 1'b0;
            check(g, "rst_in_ready",  64'(in_ready),  64'(1));
            check(g, "rst_out_valid", 64'(out_valid), 64'(0));
            check(g, "rst_s",         64'(s),         64'(0));
            check(g, "rst_cout",      64'(cout),      64'(0));
            check(g, "rst_ovf",       64'(ovf),       64'(0));

            for (int i = 0; i <= NOPS; i++) begin
                n = 0;
                while (!in_ready && n < 400) begin
                    out_ready = (g == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                    n++;
                end
                check(g, "in_ready_wait", 64'(in_ready), 64'(1));
                if (i == NOPS) break;

                act = 0;
                if (g == 0) begin
                    // Directed vectors, expected values worked by hand.
                    case (i)
                        0: begin va = NN'(8'h5A); vb = NN'(8'h3C); vc = 1'b0; es = NN'(8'h96); ec = 1'b0; eo = 1'b1; end
                        1: begin va = NN'(8'hFF); vb = NN'(8'h01); vc = 1'b0; es = NN'(8'h00); ec = 1'b1; eo = 1'b0; end
                        2: begin va = NN'(8'hFF); vb = NN'(8'h00); vc = 1'b1; es = NN'(8'h00); ec = 1'b1; eo = 1'b0; end
                        3: begin va = NN'(8'h80); vb = NN'(8'h80); vc = 1'b0; es = NN'(8'h00); ec = 1'b1; eo = 1'b1; end
                        4: begin va = NN'(8'h12); vb = NN'(8'h34); vc = 1'b0; es = NN'(8'h46); ec = 1'b0; eo = 1'b0; act = 1; end
                        5: begin va = NN'(8'hFF); vb = NN'(8'hFF); vc = 1'b1; es = NN'(8'hFF); ec = 1'b1; eo = 1'b0; act = 2; end
                        default: begin va = NN'(8'h01); vb = NN'(8'h01); vc = 1'b0; es = NN'(8'h02); ec = 1'b0; eo = 1'b0; end
                    endcase
                end else begin
                    case (i)
                        0:       begin va = '1; vb = '0; vc = 1'b1; end
                        1:       begin va = '0; va[NN-1] = 1'b1; vb = va; vc = 1'b0; end
                        2:       begin va = '1; va[NN-1] = 1'b0; vb = '0; vc = 1'b1; end
                        default: begin va = NN'($urandom); vb = NN'($urandom); vc = 1'($urandom_range(0, 1)); end
                    endcase
                    full = {1'b0, va} + {1'b0, vb} + {{NN{1'b0}}, vc};
                    es   = full[NN-1:0];
                    ec   = full[NN];
                    eo   = (va[NN-1] == vb[NN-1]) && (es[NN-1] != va[NN-1]);
                end

                a = va; b = vb; cin = vc; in_valid = 1'b1;
                if (act != 2) exp_q.push_back({ec, eo, es});
                @(posedge clk); #1;
                in_valid = 1'b0;

                if (act == 1) begin
                    // Hold the result under backpressure; in_valid pulses must be ignored.
                    out_ready = 1'b0;
                    n = 0;
                    while (!out_valid && n < 50) begin
                        check(g, "in_ready_run", 64'(in_ready), 64'(0));
                        in_valid = 1'b1; a = ~va;
                        @(posedge clk); #1;
                        n++;
                    end
                    for (int j = 0; j < 5; j++) begin
                        check(g, "hold_valid",    64'(out_valid), 64'(1));
                        check(g, "hold_s",        64'(s),         64'(es));
                        check(g, "in_ready_done", 64'(in_ready),  64'(0));
                        in_valid = j[0]; b = ~vb;
                        @(posedge clk); #1;
                    end
                    in_valid = 1'b0; a = va; b = vb;
                    out_ready = 1'b1;
                    @(posedge clk); #1;
                    check(g, "idle_after_hs_ready", 64'(in_ready),  64'(1));
                    check(g, "idle_after_hs_valid", 64'(out_valid), 64'(0));
                end else if (act == 2) begin
                    // Reset lands on the second RUN cycle; the operation is dropped.
                    @(posedge clk); #1;
                    reset = 1'b1;
                    @(posedge clk); #1;
                    reset = 1'b0;
                    check(g, "midrst_in_ready",  64'(in_ready),  64'(1));
                    check(g, "midrst_out_valid", 64'(out_valid), 64'(0));
                    check(g, "midrst_s",         64'(s),         64'(0));
                    check(g, "midrst_cout",      64'(cout),      64'(0));
                    check(g, "midrst_ovf",       64'(ovf),       64'(0));
                end
            end
            repeat (2) @(posedge clk);
            check(g, "queue_drained", 64'(exp_q.size()), 64'(0));
            done_cnt++;
        end
    end

    // Wait for every configuration to finish, with a hard cycle budget.
    initial begin
        int n;
        n = 0;
        while (done_cnt < NCFG && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < NCFG) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d finished configs expected %0d", done_cnt, NCFG);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Multi-cycle, parametrised ripple adder that adds two N-bit operands plus carry-in, K bits per clock, using one carry register between slices. It is the area-saving alternative to a flat N-bit adder in datapaths that can tolerate N/K cycles of latency. It provides carry-out and signed overflow, and uses valid/ready handshakes on both input and output.

## Interface
- N, default 32: operand width in bits; N ≥ 1.
- K, default 4: bits added per cycle; 1 ≤ K ≤ N, and N % K must be 0. Any other value is an elaboration error.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands.
- a  input  N  addend.
- b  input  N  addend.
- cin  input  1  carry-in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- s  output  N  sum, a + b + cin modulo 2^N.
- cout  output  1  carry out of bit N-1.
- ovf  output  1  two's-complement overflow.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- Acceptance: on a rising edge with state IDLE and in_valid=1:
  - Latch a, b and cin into operand shift registers and the carry register.
  - Latch a[N-1] and b[N-1] as msb_a and msb_b.
  - Clear the slice counter and go to RUN.
- RUN, each cycle:
  - Slice sum = opA[K-1:0] + opB[K-1:0] + carry, computed as (K+1) bits.
  - The low K bits shift into the top of the sum register; the sum register shifts right by K.
  - Bit K of the slice sum becomes the new carry.
  - opA and opB shift right by K, with zero fill.
  - The counter increments.
- RUN exit: after the slice with counter == N/K-1, go to DONE. At that point:
  - s holds the full sum, least-significant slice first.
  - cout = final carry.
  - ovf = (msb_a ^ msb_b ^ s[N-1]) ^ cout, i.e. carry into the MSB XOR carry out.
- DONE: hold s, cout and ovf stable until out_ready=1 at an edge, then go to IDLE. The block never drops out_valid without the handshake.
- in_valid is ignored in RUN and DONE. Operand inputs are sampled only on the accept edge, so changes after acceptance have no effect.
- s, cout and ovf are guaranteed meaningful only while out_valid=1. Outside DONE they hold the partial or previous values.
- K == N degenerate case: exactly one RUN cycle.
- Reset:
  - Forces state to IDLE, zeroes counter, carry, shift registers, s, cout and ovf.
  - in_ready=1 and out_valid=0 from the first cycle after reset.
  - Reset while in RUN or DONE discards the operation; no result is ever presented for it.
  - Reset takes priority over every simultaneous handshake.

## Timing
- All outputs are registered or decoded directly from the state register. There is no combinational path from any input to any output.
- in_ready = (state==IDLE); out_valid = (state==DONE).
- Latency: operands accepted at edge E0 → out_valid high immediately after edge E(N/K).
- Throughput: one operation per N/K+2 cycles when out_ready is held high. The three phases are accept, N/K RUN cycles, then the DONE handshake cycle returning to IDLE.
- Back-to-back operation is not supported: the IDLE cycle after DONE is mandatory. in_ready reasserts in the cycle following the output handshake edge.
- Counter width is clog2(N/K), with a minimum of 1 bit.

## Test plan
- N=8, K=2, basic sum: a=0x5A, b=0x3C, cin=0, out_ready=1 → out_valid 4 cycles after accept; s=0x96, cout=0, ovf=1.
- N=8, K=2, carry wrap: a=0xFF, b=0x01, cin=0 → s=0x00, cout=1, ovf=0. Then a=0xFF, b=0x00, cin=1 → s=0x00, cout=1, ovf=0. Then a=0x80, b=0x80, cin=0 → s=0x00, cout=1, ovf=1.
- Backpressure: a=0x12, b=0x34, with out_ready=0 for 5 cycles after out_valid rises:
  - s=0x46 stays stable and out_valid stays 1 throughout.
  - in_valid=1 pulses during RUN and DONE are ignored (in_ready=0).
  - Raising out_ready gives IDLE the next cycle.
- Reset mid-RUN: assert reset at the 2nd RUN cycle → next cycle in_ready=1, out_valid=0, s=0, cout=0, ovf=0. A following op a=0x01, b=0x01 → s=0x02, with no stale carry.
- Parameter sweep: (N,K) = (8,1), (8,8), (32,4), (32,32), with 1000 random operand sets each, including cin:
  - {cout,s} equals the (N+1)-bit reference a+b+cin.
  - ovf matches the signed-overflow reference.
  - Latency is exactly N/K cycles.
